// File: rtl/kernel_pingpong_ram.sv
`default_nettype none
// ============================================================================
// Module   : kernel_pingpong_ram
// Brief    : Double-buffered weight RAM. One buffer is loaded bank by bank
//            while the other serves wide multi-bank kernel reads. The roles
//            of the two buffers are exchanged on request once a load is
//            complete.
// Revision : 1.0 - initial release
// ============================================================================
module kernel_pingpong_ram #(
  parameter int unsigned pWEIGHT_DATA_WIDTH = 64,
  parameter logic [31:0] pWEIGHT_BASE_ADDR  = 32'h4000_0000,
  parameter int unsigned pKERNEL_NUM        = 1024,
  parameter int unsigned pBANK_NUM          = 8,
  parameter int unsigned pRD_LATENCY        = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wr_en,
  input  logic [31:0]                             weight_addr,
  input  logic [pWEIGHT_DATA_WIDTH-1:0]           weight_data,
  input  logic                                    swap_req,
  input  logic                                    rd_en,
  input  logic [$clog2(pKERNEL_NUM)-1:0]          kernel_addr,
  output logic [pWEIGHT_DATA_WIDTH*pBANK_NUM-1:0] kernel_data,
  output logic                                    rd_valid,
  output logic                                    load_full,
  output logic                                    active_sel,
  output logic                                    active_valid,
  output logic                                    wr_drop
);

  localparam int unsigned W     = pWEIGHT_DATA_WIDTH;
  localparam int unsigned AW    = $clog2(pKERNEL_NUM);
  localparam int unsigned BW    = (pBANK_NUM > 1) ? $clog2(pBANK_NUM) : 1;
  localparam int unsigned TOTAL = pBANK_NUM * pKERNEL_NUM;
  localparam int unsigned CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(TOTAL - 1);
  localparam logic [BW-1:0] LAST_BANK = BW'(pBANK_NUM - 1);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   load_cnt_q, load_cnt_d;
  logic [BW-1:0]   wr_bank_q, wr_bank_d;
  logic            active_sel_q, active_sel_d;
  logic            active_valid_q, active_valid_d;
  logic            wr_drop_q, wr_drop_d;

  logic [W-1:0]    mem_q [2][pBANK_NUM][pKERNEL_NUM];

  logic [31:0]     w_off;
  logic            w_in_range;
  logic            w_wr_accept;
  logic [AW-1:0]   w_wr_word;
  logic [AW-1:0]   w_rd_idx;
  logic [W*pBANK_NUM-1:0] w_rd_word;

  logic [W*pBANK_NUM-1:0] kernel_data_q;
  logic                   rd_valid_q;

  // Upper bits of the offset take part in the range check, so the window is
  // exactly pKERNEL_NUM words starting at the base address.
  assign w_off       = weight_addr - pWEIGHT_BASE_ADDR;
  assign w_in_range  = (weight_addr >= pWEIGHT_BASE_ADDR) && (w_off < 32'(pKERNEL_NUM));
  assign w_wr_accept = wr_en && (state_q == ST_LOAD) && w_in_range;
  assign w_wr_word   = w_off[AW-1:0];
  // Out-of-range read indices are folded to word 0 so no illegal array access occurs.
  assign w_rd_idx    = (32'(kernel_addr) < pKERNEL_NUM) ? kernel_addr : '0;

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_LOAD;
      load_cnt_q     <= '0;
      wr_bank_q      <= '0;
      active_sel_q   <= 1'b0;
      active_valid_q <= 1'b0;
      wr_drop_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      load_cnt_q     <= load_cnt_d;
      wr_bank_q      <= wr_bank_d;
      active_sel_q   <= active_sel_d;
      active_valid_q <= active_valid_d;
      wr_drop_q      <= wr_drop_d;
    end
  end

  // Next-state logic: count accepted writes in LOAD, exchange buffers from FULL.
  always_comb begin
    state_d        = state_q;
    load_cnt_d     = load_cnt_q;
    wr_bank_d      = wr_bank_q;
    active_sel_d   = active_sel_q;
    active_valid_d = active_valid_q;
    wr_drop_d      = wr_drop_q | (wr_en & ~w_wr_accept);
    case (state_q)
      ST_LOAD: begin
        if (w_wr_accept) begin
          load_cnt_d = load_cnt_q + CW'(1);
          wr_bank_d  = (wr_bank_q == LAST_BANK) ? '0 : wr_bank_q + BW'(1);
          if (load_cnt_q == LAST_CNT) begin
            state_d = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (swap_req) begin
          state_d        = ST_LOAD;
          active_sel_d   = ~active_sel_q;
          active_valid_d = 1'b1;
          load_cnt_d     = '0;
          wr_bank_d      = '0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Load-buffer write port; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_accept) begin
      mem_q[~active_sel_q][wr_bank_q][w_wr_word] <= weight_data;
    end
  end

  // Gather the addressed word from every bank of the active buffer.
  for (genvar b = 0; b < pBANK_NUM; b++) begin : g_rd_bank
    assign w_rd_word[b*W +: W] = mem_q[active_sel_q][b][w_rd_idx];
  end

  if (pRD_LATENCY == 1) begin : g_lat1
    // Single-stage read: capture on rd_en, hold otherwise.
    always_ff @(posedge clk) begin
      if (rst) begin
        kernel_data_q <= '0;
        rd_valid_q    <= 1'b0;
      end else begin
        rd_valid_q <= rd_en;
        if (rd_en) begin
          kernel_data_q <= w_rd_word;
        end
      end
    end
  end else begin : g_lat2
    logic [W*pBANK_NUM-1:0] s1_data_q;
    logic                   s1_valid_q;
    // Two-stage read: the first stage samples the buffer, the second presents it.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_data_q     <= '0;
        s1_valid_q    <= 1'b0;
        kernel_data_q <= '0;
        rd_valid_q    <= 1'b0;
      end else begin
        s1_valid_q <= rd_en;
        if (rd_en) begin
          s1_data_q <= w_rd_word;
        end
        rd_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          kernel_data_q <= s1_data_q;
        end
      end
    end
  end

  assign kernel_data  = kernel_data_q;
  assign rd_valid     = rd_valid_q;
  assign load_full    = (state_q == ST_FULL);
  assign active_sel   = active_sel_q;
  assign active_valid = active_valid_q;
  assign wr_drop      = wr_drop_q;

endmodule
`default_nettype wire
